// File: rtl/ctrl_pipe.sv
// ctrl_pipe: RV32I control path. Decodes in ID, carries the control bundle
// through EX/MEM/WB, resolves branches and jumps in EX, flags illegal
// instructions and counts retired instructions.
module ctrl_pipe #(
    parameter int unsigned ALUCTRL_W  = 4,
    parameter bit          BRANCH_EXT = 1'b1,
    parameter int unsigned CNT_W      = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 instr_valid_d,
    input  logic [6:0]           op_d,
    input  logic [2:0]           funct3_d,
    input  logic                 funct7b5_d,
    input  logic                 flush_e,
    input  logic                 zero_e,
    input  logic                 lt_e,
    input  logic                 ltu_e,
    output logic [2:0]           immsrc_d,
    output logic                 illegal_d,
    output logic                 illegal_seen,
    output logic                 regwrite_e,
    output logic                 memread_e,
    output logic                 alusrc_e,
    output logic                 alusrca_e,
    output logic                 jalr_e,
    output logic                 pcsrc_e,
    output logic [ALUCTRL_W-1:0] alucontrol_e,
    output logic                 regwrite_m,
    output logic                 memwrite_m,
    output logic [1:0]           resultsrc_m,
    output logic                 regwrite_w,
    output logic [1:0]           resultsrc_w,
    output logic [CNT_W-1:0]     instret
);

    localparam logic [6:0] OpR      = 7'b0110011;
    localparam logic [6:0] OpI      = 7'b0010011;
    localparam logic [6:0] OpLoad   = 7'b0000011;
    localparam logic [6:0] OpStore  = 7'b0100011;
    localparam logic [6:0] OpBranch = 7'b1100011;
    localparam logic [6:0] OpJal    = 7'b1101111;
    localparam logic [6:0] OpJalr   = 7'b1100111;
    localparam logic [6:0] OpLui    = 7'b0110111;
    localparam logic [6:0] OpAuipc  = 7'b0010111;

    localparam logic [3:0] AluAdd  = 4'b0000;
    localparam logic [3:0] AluSub  = 4'b0001;
    localparam logic [3:0] AluAnd  = 4'b0010;
    localparam logic [3:0] AluOr   = 4'b0011;
    localparam logic [3:0] AluXor  = 4'b0100;
    localparam logic [3:0] AluSlt  = 4'b0101;
    localparam logic [3:0] AluPassB = 4'b0110;
    localparam logic [3:0] AluSltu = 4'b0111;
    localparam logic [3:0] AluSll  = 4'b1000;
    localparam logic [3:0] AluSrl  = 4'b1001;
    localparam logic [3:0] AluSra  = 4'b1010;

    // Decoded bundle in ID
    logic       dec_ok;
    logic       dec_regwrite, dec_memread, dec_memwrite;
    logic [1:0] dec_resultsrc;
    logic       dec_alusrc, dec_alusrca, dec_jump, dec_jalr, dec_branch;
    logic [3:0] dec_alu;
    logic [3:0] f3_alu;
    logic       branch_f3_ok;
    logic       issue;

    // EX-only state
    logic       valid_e, memwrite_e, jump_e, branch_e;
    logic [1:0] resultsrc_e;
    logic [2:0] funct3_e;
    logic       branch_cond;

    // MEM/WB valid bits
    logic       valid_m, valid_w;

    // 000/001 always decode; 1xx only with the extended branch set
    assign branch_f3_ok = funct3_d[2] ? BRANCH_EXT : ~funct3_d[1];

    // ALU operation selected by funct3 for R and I-ALU formats
    always_comb begin
        f3_alu = AluAdd;
        case (funct3_d)
            3'b000: f3_alu = (op_d == OpR && funct7b5_d) ? AluSub : AluAdd;
            3'b001: f3_alu = AluSll;
            3'b010: f3_alu = AluSlt;
            3'b011: f3_alu = AluSltu;
            3'b100: f3_alu = AluXor;
            3'b101: f3_alu = funct7b5_d ? AluSra : AluSrl;
            3'b110: f3_alu = AluOr;
            default: f3_alu = AluAnd;
        endcase
    end

    // Main opcode decode
    always_comb begin
        dec_ok        = 1'b0;
        dec_regwrite  = 1'b0;
        dec_memread   = 1'b0;
        dec_memwrite  = 1'b0;
        dec_resultsrc = 2'b00;
        dec_alusrc    = 1'b0;
        dec_alusrca   = 1'b0;
        dec_jump      = 1'b0;
        dec_jalr      = 1'b0;
        dec_branch    = 1'b0;
        dec_alu       = AluAdd;
        immsrc_d      = 3'b000;
        case (op_d)
            OpR: begin
                dec_ok       = 1'b1;
                dec_regwrite = 1'b1;
                dec_alu      = f3_alu;
            end
            OpI: begin
                dec_ok       = 1'b1;
                dec_regwrite = 1'b1;
                dec_alusrc   = 1'b1;
                dec_alu      = f3_alu;
            end
            OpLoad: begin
                dec_ok        = 1'b1;
                dec_regwrite  = 1'b1;
                dec_memread   = 1'b1;
                dec_resultsrc = 2'b01;
                dec_alusrc    = 1'b1;
            end
            OpStore: begin
                dec_ok       = 1'b1;
                dec_memwrite = 1'b1;
                dec_alusrc   = 1'b1;
                immsrc_d     = 3'b001;
            end
            OpBranch: begin
                dec_ok     = branch_f3_ok;
                dec_branch = 1'b1;
                dec_alu    = AluSub;
                immsrc_d   = 3'b010;
            end
            OpJal: begin
                dec_ok        = 1'b1;
                dec_regwrite  = 1'b1;
                dec_resultsrc = 2'b10;
                dec_jump      = 1'b1;
                immsrc_d      = 3'b011;
            end
            OpJalr: begin
                dec_ok        = 1'b1;
                dec_regwrite  = 1'b1;
                dec_resultsrc = 2'b10;
                dec_jump      = 1'b1;
                dec_jalr      = 1'b1;
                dec_alusrc    = 1'b1;
            end
            OpLui: begin
                dec_ok       = 1'b1;
                dec_regwrite = 1'b1;
                dec_alusrc   = 1'b1;
                dec_alu      = AluPassB;
                immsrc_d     = 3'b100;
            end
            OpAuipc: begin
                dec_ok       = 1'b1;
                dec_regwrite = 1'b1;
                dec_alusrc   = 1'b1;
                dec_alusrca  = 1'b1;
                immsrc_d     = 3'b100;
            end
            default: dec_ok = 1'b0;
        endcase
    end

    assign illegal_d = instr_valid_d & ~dec_ok;
    assign issue     = instr_valid_d & dec_ok & ~flush_e;

    // ID->EX register; anything not issued enters as an all-zero bubble
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_e      <= 1'b0;
            regwrite_e   <= 1'b0;
            memread_e    <= 1'b0;
            memwrite_e   <= 1'b0;
            resultsrc_e  <= 2'b00;
            alusrc_e     <= 1'b0;
            alusrca_e    <= 1'b0;
            jump_e       <= 1'b0;
            jalr_e       <= 1'b0;
            branch_e     <= 1'b0;
            funct3_e     <= 3'b000;
            alucontrol_e <= '0;
        end else if (issue) begin
            valid_e      <= 1'b1;
            regwrite_e   <= dec_regwrite;
            memread_e    <= dec_memread;
            memwrite_e   <= dec_memwrite;
            resultsrc_e  <= dec_resultsrc;
            alusrc_e     <= dec_alusrc;
            alusrca_e    <= dec_alusrca;
            jump_e       <= dec_jump;
            jalr_e       <= dec_jalr;
            branch_e     <= dec_branch;
            funct3_e     <= funct3_d;
            alucontrol_e <= ALUCTRL_W'(dec_alu);
        end else begin
            valid_e      <= 1'b0;
            regwrite_e   <= 1'b0;
            memread_e    <= 1'b0;
            memwrite_e   <= 1'b0;
            resultsrc_e  <= 2'b00;
            alusrc_e     <= 1'b0;
            alusrca_e    <= 1'b0;
            jump_e       <= 1'b0;
            jalr_e       <= 1'b0;
            branch_e     <= 1'b0;
            funct3_e     <= 3'b000;
            alucontrol_e <= '0;
        end
    end

    // Branch condition from ALU flags, selected by the EX funct3
    always_comb begin
        branch_cond = 1'b0;
        case (funct3_e)
            3'b000: branch_cond = zero_e;
            3'b001: branch_cond = ~zero_e;
            3'b100: branch_cond = lt_e;
            3'b101: branch_cond = ~lt_e;
            3'b110: branch_cond = ltu_e;
            3'b111: branch_cond = ~ltu_e;
            default: branch_cond = 1'b0;
        endcase
    end

    assign pcsrc_e = valid_e & (jump_e | (branch_e & branch_cond));

    // EX->MEM and MEM->WB registers advance every cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_m     <= 1'b0;
            regwrite_m  <= 1'b0;
            memwrite_m  <= 1'b0;
            resultsrc_m <= 2'b00;
            valid_w     <= 1'b0;
            regwrite_w  <= 1'b0;
            resultsrc_w <= 2'b00;
        end else begin
            valid_m     <= valid_e;
            regwrite_m  <= regwrite_e;
            memwrite_m  <= memwrite_e;
            resultsrc_m <= resultsrc_e;
            valid_w     <= valid_m;
            regwrite_w  <= regwrite_m;
            resultsrc_w <= resultsrc_m;
        end
    end

    // Retirement counter and sticky illegal flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            instret      <= '0;
            illegal_seen <= 1'b0;
        end else begin
            if (valid_w) begin
                instret <= instret + CNT_W'(1);
            end
            if (illegal_d) begin
                illegal_seen <= 1'b1;
            end
        end
    end

endmodule
